// File: rtl/registro_datos_rtc.sv
// Shadow bank of packed-BCD RTC fields, committed to registered ASCII digits only during vertical blanking.
// Optional macro CONFIG_FORMATO_12H_EN converts the hour field to 12 h format and drives pm.
module registro_datos_rtc #(
    parameter logic [9:0] V_ACTIVE = 10'd480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] dir_in,
    input  logic [7:0] dato_in,
    input  logic [9:0] pixely,
    output logic [6:0] SegundosU,
    output logic [6:0] SegundosD,
    output logic [6:0] minutosU,
    output logic [6:0] minutosD,
    output logic [6:0] horasU,
    output logic [6:0] horasD,
    output logic [6:0] fechaU,
    output logic [6:0] fechaD,
    output logic [6:0] mesU,
    output logic [6:0] mesD,
    output logic [6:0] anoU,
    output logic [6:0] anoD,
    output logic [6:0] diaSemanaU,
    output logic [6:0] diaSemanaD,
    output logic [6:0] numeroSemanaU,
    output logic [6:0] numeroSemanaD,
    output logic       pm,
    output logic       actualizado,
    output logic       error_bcd
);

    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] PENDIENTE = 1'b1;
    localparam logic [2:0] DIR_HORA  = 3'd2;

    logic [0:0] state_reg;
    logic [0:0] state_next;
    logic       actualizado_reg;
    logic       error_bcd_reg;

    logic [7:0] shadow_reg    [8];
    logic [7:0] valor_commit  [8];
    logic [6:0] digito_d_reg  [8];
    logic [6:0] digito_u_reg  [8];

    logic       dato_valido;
    logic       escritura_ok;
    logic       escritura_mala;
    logic       en_blanking;
    logic       commit;
    logic [7:0] hora_commit;

    assign dato_valido    = (dato_in[7:4] <= 4'd9) && (dato_in[3:0] <= 4'd9);
    assign escritura_ok   = wr_en && dato_valido;
    assign escritura_mala = wr_en && !dato_valido;
    assign en_blanking    = (pixely >= V_ACTIVE);
    assign commit         = (state_reg == PENDIENTE) && en_blanking;

    // A write landing on the commit cycle keeps the FSM pending so that value is shown next blanking cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (escritura_ok) state_next = PENDIENTE;
            PENDIENTE: if (commit)       state_next = escritura_ok ? PENDIENTE : IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            actualizado_reg <= 1'b0;
            error_bcd_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            actualizado_reg <= commit;
            if (escritura_mala)
                error_bcd_reg <= 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_campo
            localparam logic [2:0] IDX = 3'(gi);

            always_ff @(posedge clk) begin
                if (reset)
                    shadow_reg[gi] <= 8'h00;
                else if (escritura_ok && (dir_in == IDX))
                    shadow_reg[gi] <= dato_in;
            end

            if (gi == 2) begin : g_hora
                assign valor_commit[gi] = hora_commit;
            end else begin : g_directo
                assign valor_commit[gi] = shadow_reg[gi];
            end

            // Non-blocking read of the shadow means a same-cycle write is not part of this commit.
            always_ff @(posedge clk) begin
                if (reset) begin
                    digito_d_reg[gi] <= 7'h30;
                    digito_u_reg[gi] <= 7'h30;
                end else if (commit) begin
                    digito_d_reg[gi] <= {3'b011, valor_commit[gi][7:4]};
                    digito_u_reg[gi] <= {3'b011, valor_commit[gi][3:0]};
                end
            end
        end
    endgenerate

`ifdef CONFIG_FORMATO_12H_EN
    logic       pm_reg;
    logic       pm_commit;

    // Returns {pm, bcd}; hours outside 0..23 pass through untouched with pm low.
    function automatic logic [8:0] a_formato_12h(input logic [7:0] bcd);
        logic [6:0] bin;
        logic [6:0] v;
        logic [6:0] v_menos_10;
        logic [8:0] res;
        bin        = 7'(bcd[7:4]) * 7'd10 + 7'(bcd[3:0]);
        v          = bin - 7'd12;
        v_menos_10 = v - 7'd10;
        if (bin == 7'd0)
            res = {1'b0, 8'h12};
        else if (bin < 7'd12)
            res = {1'b0, bcd};
        else if (bin == 7'd12)
            res = {1'b1, 8'h12};
        else if (bin <= 7'd23)
            res = (v >= 7'd10) ? {1'b1, 4'd1, v_menos_10[3:0]} : {1'b1, 4'd0, v[3:0]};
        else
            res = {1'b0, bcd};
        return res;
    endfunction

    assign {pm_commit, hora_commit} = a_formato_12h(shadow_reg[DIR_HORA]);

    always_ff @(posedge clk) begin
        if (reset)
            pm_reg <= 1'b0;
        else if (commit)
            pm_reg <= pm_commit;
    end

    assign pm = pm_reg;
`else
    assign hora_commit = shadow_reg[DIR_HORA];
    assign pm          = 1'b0;
`endif

    assign SegundosU     = digito_u_reg[0];
    assign SegundosD     = digito_d_reg[0];
    assign minutosU      = digito_u_reg[1];
    assign minutosD      = digito_d_reg[1];
    assign horasU        = digito_u_reg[2];
    assign horasD        = digito_d_reg[2];
    assign fechaU        = digito_u_reg[3];
    assign fechaD        = digito_d_reg[3];
    assign mesU          = digito_u_reg[4];
    assign mesD          = digito_d_reg[4];
    assign anoU          = digito_u_reg[5];
    assign anoD          = digito_d_reg[5];
    assign diaSemanaU    = digito_u_reg[6];
    assign diaSemanaD    = digito_d_reg[6];
    assign numeroSemanaU = digito_u_reg[7];
    assign numeroSemanaD = digito_d_reg[7];
    assign actualizado   = actualizado_reg;
    assign error_bcd     = error_bcd_reg;

endmodule

// File: tb/tb_registro_datos_rtc.sv
// Directed bench for registro_datos_rtc: blanking-gated commits, BCD rejection, same-cycle conflict, 12 h mode.
module tb_registro_datos_rtc;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [2:0] dir_in;
    logic [7:0] dato_in;
    logic [9:0] pixely;
    logic [6:0] SegundosU, SegundosD, minutosU, minutosD, horasU, horasD;
    logic [6:0] fechaU, fechaD, mesU, mesD, anoU, anoD;
    logic [6:0] diaSemanaU, diaSemanaD, numeroSemanaU, numeroSemanaD;
    logic       pm, actualizado, error_bcd;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    registro_datos_rtc #(.V_ACTIVE(10'd480)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .dir_in(dir_in), .dato_in(dato_in),
        .pixely(pixely),
        .SegundosU(SegundosU), .SegundosD(SegundosD), .minutosU(minutosU), .minutosD(minutosD),
        .horasU(horasU), .horasD(horasD), .fechaU(fechaU), .fechaD(fechaD),
        .mesU(mesU), .mesD(mesD), .anoU(anoU), .anoD(anoD),
        .diaSemanaU(diaSemanaU), .diaSemanaD(diaSemanaD),
        .numeroSemanaU(numeroSemanaU), .numeroSemanaD(numeroSemanaD),
        .pm(pm), .actualizado(actualizado), .error_bcd(error_bcd)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called at a falling edge; returns at the falling edge after the strobe was sampled.
    task automatic wr(input logic [2:0] d, input logic [7:0] v);
        wr_en   = 1'b1;
        dir_in  = d;
        dato_in = v;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; dir_in = 3'd0; dato_in = 8'h00; pixely = 10'd500;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_SegD", 8'(SegundosD), 8'h30);      chk("rst_SegU", 8'(SegundosU), 8'h30);
        chk("rst_minD", 8'(minutosD), 8'h30);       chk("rst_horU", 8'(horasU), 8'h30);
        chk("rst_mesD", 8'(mesD), 8'h30);           chk("rst_anoU", 8'(anoU), 8'h30);
        chk("rst_numD", 8'(numeroSemanaD), 8'h30);  chk("rst_pm", 8'(pm), 8'h00);
        chk("rst_err", 8'(error_bcd), 8'h00);       chk("rst_act", 8'(actualizado), 8'h00);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_blank_act", 8'(actualizado), 8'h00);
        end

        // Write during active region
        pixely = 10'd100;
        wr(3'd0, 8'h45);
        for (int i = 0; i < 3; i++) begin
            chk("act_SegD_hold", 8'(SegundosD), 8'h30);
            chk("act_act_low", 8'(actualizado), 8'h00);
            @(negedge clk);
        end
        pixely = 10'd480;
        @(negedge clk);
        chk("act_SegD", 8'(SegundosD), 8'h34);
        chk("act_SegU", 8'(SegundosU), 8'h35);
        chk("act_pulse", 8'(actualizado), 8'h01);
        @(negedge clk);
        chk("act_pulse_end", 8'(actualizado), 8'h00);

        // Write during blanking: two-cycle latency
        pixely = 10'd490;
        wr(3'd5, 8'h17);
        chk("blk_anoD_early", 8'(anoD), 8'h30);
        chk("blk_act_early", 8'(actualizado), 8'h00);
        @(negedge clk);
        chk("blk_anoD", 8'(anoD), 8'h31);
        chk("blk_anoU", 8'(anoU), 8'h37);
        chk("blk_pulse", 8'(actualizado), 8'h01);
        @(negedge clk);
        chk("blk_pulse_end", 8'(actualizado), 8'h00);

        // Invalid BCD rejected, error sticky
        wr(3'd4, 8'h1A);
        chk("bad_err", 8'(error_bcd), 8'h01);
        @(negedge clk);
        chk("bad_act", 8'(actualizado), 8'h00);
        chk("bad_mesD", 8'(mesD), 8'h30);
        chk("bad_mesU", 8'(mesU), 8'h30);
        wr(3'd4, 8'h12);
        @(negedge clk);
        chk("ok_mesD", 8'(mesD), 8'h31);
        chk("ok_mesU", 8'(mesU), 8'h32);
        chk("ok_err_sticky", 8'(error_bcd), 8'h01);

        // Same-cycle write and commit
        pixely = 10'd100;
        wr(3'd2, 8'h10);
        pixely = 10'd480;
        wr(3'd2, 8'h11);
        chk("conf_horD", 8'(horasD), 8'h31);
        chk("conf_horU", 8'(horasU), 8'h30);
        chk("conf_pulse1", 8'(actualizado), 8'h01);
        @(negedge clk);
        chk("conf_horU2", 8'(horasU), 8'h31);
        chk("conf_pulse2", 8'(actualizado), 8'h01);
        @(negedge clk);
        chk("conf_pulse_end", 8'(actualizado), 8'h00);

        // Several writes before blanking, one commit
        pixely = 10'd100;
        wr(3'd1, 8'h23);
        wr(3'd1, 8'h59);
        wr(3'd6, 8'h03);
        wr(3'd7, 8'h52);
        chk("multi_minD_hold", 8'(minutosD), 8'h30);
        pixely = 10'd481;
        @(negedge clk);
        chk("multi_minD", 8'(minutosD), 8'h35);
        chk("multi_minU", 8'(minutosU), 8'h39);
        chk("multi_diaU", 8'(diaSemanaU), 8'h33);
        chk("multi_numD", 8'(numeroSemanaD), 8'h35);
        chk("multi_numU", 8'(numeroSemanaU), 8'h32);
        chk("multi_pulse", 8'(actualizado), 8'h01);
        @(negedge clk);
        chk("multi_pulse_end", 8'(actualizado), 8'h00);

        // Hour format
        pixely = 10'd490;
`ifdef CONFIG_FORMATO_12H_EN
        wr(3'd2, 8'h00); @(negedge clk);
        chk("h00_D", 8'(horasD), 8'h31); chk("h00_U", 8'(horasU), 8'h32); chk("h00_pm", 8'(pm), 8'h00);
        wr(3'd2, 8'h13); @(negedge clk);
        chk("h13_D", 8'(horasD), 8'h30); chk("h13_U", 8'(horasU), 8'h31); chk("h13_pm", 8'(pm), 8'h01);
        wr(3'd2, 8'h21); @(negedge clk);
        chk("h21_D", 8'(horasD), 8'h30); chk("h21_U", 8'(horasU), 8'h39); chk("h21_pm", 8'(pm), 8'h01);
        wr(3'd2, 8'h12); @(negedge clk);
        chk("h12_D", 8'(horasD), 8'h31); chk("h12_U", 8'(horasU), 8'h32); chk("h12_pm", 8'(pm), 8'h01);
`else
        wr(3'd2, 8'h21); @(negedge clk);
        chk("h21_D", 8'(horasD), 8'h32); chk("h21_U", 8'(horasU), 8'h31); chk("h21_pm", 8'(pm), 8'h00);
`endif

        // Reset discards a pending update
        pixely = 10'd100;
        wr(3'd0, 8'h99);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pixely = 10'd480;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstmid_act", 8'(actualizado), 8'h00);
        end
        chk("rstmid_SegD", 8'(SegundosD), 8'h30);
        chk("rstmid_horD", 8'(horasD), 8'h30);
        chk("rstmid_err", 8'(error_bcd), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
